// File: rtl/inv_round_linear_pipe_if.sv
// rtl/inv_round_linear_pipe_if.sv - input/output stream bundle for the inverse-round linear pipe
interface inv_round_linear_pipe_if #(
    parameter int BLOCK_LENGTH = 128
);
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [BLOCK_LENGTH-1:0] IN;
    logic [BLOCK_LENGTH-1:0] ROUND_KEY;
    logic                    LAST_ROUND;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [BLOCK_LENGTH-1:0] OUT;

    modport master (
        output IN_VALID, IN, ROUND_KEY, LAST_ROUND, OUT_READY,
        input  IN_READY, OUT_VALID, OUT
    );

    modport slave (
        input  IN_VALID, IN, ROUND_KEY, LAST_ROUND, OUT_READY,
        output IN_READY, OUT_VALID, OUT
    );
endinterface

// File: rtl/inv_round_linear_pipe.sv
// rtl/inv_round_linear_pipe.sv - InvShiftRows, AddRoundKey, InvMixColumns in a 2-stage elastic pipe
module inv_round_linear_pipe #(
    parameter int BLOCK_LENGTH = 128
) (
    input logic                  CLK,
    input logic                  RST,
    inv_round_linear_pipe_if.slave bus
);
    generate
        if (BLOCK_LENGTH != 128) begin : g_bad_width
            $error("inv_round_linear_pipe supports BLOCK_LENGTH = 128 only");
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] r_s1_data;
    logic [127:0] r_s2_data;
    logic         r_s1_last;
    logic         r_s1_valid;
    logic         r_s2_valid;

    logic         w_adv1;
    logic         w_adv2;
    logic [127:0] w_isr;
    logic [127:0] w_s1_next;
    logic [127:0] w_imc;

    assign w_adv2 = !r_s2_valid || bus.OUT_READY;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Output byte r+4c takes input byte r+4((c-r) mod 4).
    always_comb begin
        w_isr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_isr[127-8*(r+4*c) -: 8] = bus.IN[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
    end

    assign w_s1_next = w_isr ^ bus.ROUND_KEY;

    always_comb begin
        w_imc = '0;
        for (int c = 0; c < 4; c++) begin
            w_imc[127-32*c -: 32] = inv_mix_col(r_s1_data[127-32*c -: 32]);
        end
    end

    // Data registers only move with a valid beat so OUT stays put between beats.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    r_s1_data <= w_s1_next;
                    r_s1_last <= bus.LAST_ROUND;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_last ? r_s1_data : w_imc;
                end
            end
        end
    end

    assign bus.IN_READY  = w_adv1;
    assign bus.OUT_VALID = r_s2_valid;
    assign bus.OUT       = r_s2_data;
endmodule

// File: tb/tb_inv_round_linear_pipe.sv
// tb/tb_inv_round_linear_pipe.sv - scoreboard bench for inv_round_linear_pipe
module tb_inv_round_linear_pipe;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    inv_round_linear_pipe_if #(.BLOCK_LENGTH(128)) bus ();

    inv_round_linear_pipe #(.BLOCK_LENGTH(128)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [127:0] q_data [$];
    int           q_cyc  [$];
    logic [127:0] exp_next;
    logic         lat_mode   = 1'b0;
    logic         acc_in_d   = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_out   = '0;
    int           stalls_seen = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] din, input logic [127:0] key,
                                               input logic last);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] u [16];
        logic [7:0] coef [4];
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int k = 0; k < 16; k++) s[k] = din[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = s[r+4*((c-r+4)%4)] ^ key[127-8*(r+4*c) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                u[r+4*c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    u[r+4*c] = u[r+4*c] ^ gmul(coef[(j-r+4)%4], t[j+4*c]);
            end
        res = '0;
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = last ? t[k] : u[k];
        return res;
    endfunction

    task automatic drive(input logic v, input logic [127:0] din, input logic [127:0] key,
                         input logic last, input logic rdy, input logic [127:0] exp);
        bus.IN_VALID   = v;
        bus.IN         = din;
        bus.ROUND_KEY  = key;
        bus.LAST_ROUND = last;
        bus.OUT_READY  = rdy;
        exp_next       = exp;
    endtask

    task automatic step();
        logic acc_out, acc_in;
        logic [127:0] e;
        int pc;
        @(negedge CLK);
        acc_out = bus.OUT_VALID && bus.OUT_READY;
        acc_in  = bus.IN_VALID && bus.IN_READY;
        chk("in_ready", {127'd0, bus.IN_READY},
            {127'd0, !(q_data.size() == 2 && !bus.OUT_READY)});
        if (!bus.IN_READY) stalls_seen++;
        if (bus.OUT_VALID) chk("no_spurious_out", {127'd0, q_data.size() != 0}, 128'd1);
        if (prev_stall) begin
            chk("stall_valid_held", {127'd0, bus.OUT_VALID}, 128'd1);
            chk("stall_data_held", bus.OUT, prev_out);
        end
        if (acc_out && q_data.size() != 0) begin
            e  = q_data.pop_front();
            pc = q_cyc.pop_front();
            chk("out_data", bus.OUT, e);
            if (lat_mode) chk("latency", 128'(cyc - pc), 128'd2);
        end
        if (acc_in) begin
            q_data.push_back(exp_next);
            q_cyc.push_back(cyc);
        end
        acc_in_d   = acc_in;
        prev_stall = bus.OUT_VALID && !bus.OUT_READY;
        prev_out   = bus.OUT;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drain(input logic [3:0] pat);
        int k = 0;
        while (q_data.size() != 0 && k < 60) begin
            drive(1'b0, '0, '0, 1'b0, pat[k%4], '0);
            step();
            k++;
        end
        chk("drain_empty", 128'(q_data.size()), 128'd0);
    endtask

    logic [127:0] beats [16];
    logic [127:0] keys  [16];
    logic [127:0] v_isr_in, v_key, v_c6, v_01, v_mc;

    initial begin
        v_isr_in = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        v_key    = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        v_c6     = {16{8'hc6}};
        v_01     = {16{8'h01}};
        v_mc     = {4{32'h8e4da1bc}};

        drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
        #12;
        chk("reset_out_valid", {127'd0, bus.OUT_VALID}, 128'd0);
        chk("reset_out", bus.OUT, '0);
        chk("reset_in_ready", {127'd0, bus.IN_READY}, 128'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        step();

        // InvShiftRows mapping with explicit latency probe.
        lat_mode = 1'b1;
        drive(1'b1, v_isr_in, '0, 1'b1, 1'b1, 128'h000d0a07_04010e0b_0805020f_0c090603);
        step();
        chk("isr_not_early", {127'd0, bus.OUT_VALID}, 128'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
        step();
        chk("isr_visible", {127'd0, bus.OUT_VALID}, 128'd1);
        chk("isr_value", bus.OUT, 128'h000d0a07_04010e0b_0805020f_0c090603);
        drain(4'b1111);

        drive(1'b1, v_c6, '0, 1'b0, 1'b1, v_c6);                    step();
        drive(1'b1, v_01, '0, 1'b0, 1'b1, v_01);                    step();
        drive(1'b1, v_mc, '0, 1'b0, 1'b1, {4{32'hdb135345}});       step();
        drive(1'b1, '0, v_key, 1'b1, 1'b1, v_key);                  step();
        drive(1'b1, '0, v_key, 1'b0, 1'b1, ref_round('0, v_key, 1'b0)); step();
        drain(4'b1111);
        chk("model_mc_const", ref_round(v_mc, '0, 1'b0), {4{32'hdb135345}});

        // Backpressure: OUT_READY pattern 1,0,0,1 repeating.
        lat_mode    = 1'b0;
        stalls_seen = 0;
        for (int i = 0; i < 5; i++) begin
            beats[i] = {$urandom, $urandom, $urandom, $urandom};
            keys[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        begin
            int sent = 0;
            int k    = 0;
            while (sent < 5 && k < 60) begin
                drive(1'b1, beats[sent], keys[sent], sent[0], (k % 4 == 0) || (k % 4 == 3),
                      ref_round(beats[sent], keys[sent], sent[0]));
                step();
                if (acc_in_d) sent++;
                k++;
            end
            chk("bp_all_sent", 128'(sent), 128'd5);
        end
        drain(4'b1001);
        chk("bp_in_ready_fell", {127'd0, stalls_seen != 0}, 128'd1);

        // Throughput: 16 back-to-back beats, LAST_ROUND alternating.
        lat_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beats[i] = {$urandom, $urandom, $urandom, $urandom};
            keys[i]  = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b1, beats[i], keys[i], i[0], 1'b1, ref_round(beats[i], keys[i], i[0]));
            step();
            chk("tp_accept", {127'd0, acc_in_d}, 128'd1);
        end
        drain(4'b1111);

        // Reset with two beats in flight.
        lat_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, beats[i], keys[i], 1'b0, 1'b0, ref_round(beats[i], keys[i], 1'b0));
            step();
        end
        RST = 1'b0;
        #2;
        chk("midrst_out_valid", {127'd0, bus.OUT_VALID}, 128'd0);
        chk("midrst_out", bus.OUT, '0);
        chk("midrst_in_ready", {127'd0, bus.IN_READY}, 128'd1);
        q_data.delete();
        q_cyc.delete();
        prev_stall = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
            step();
            chk("postrst_no_stale", {127'd0, bus.OUT_VALID}, 128'd0);
            chk("postrst_out_zero", bus.OUT, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
